// File: rtl/add_pkg.sv
// Shared constants and state encoding for the operand loader in front of the
// external 35-bit adder.
//   ADD_WIDTH  : operand and sum width in bits
//   ADD_NBYTES : bytes per operand, ceil(ADD_WIDTH/8)
//   CNT_W      : width of the byte counter (covers 0 .. 2*ADD_NBYTES-1)
//   state_t    : loader FSM states
package add_pkg;

    localparam int ADD_WIDTH  = 35;
    localparam int ADD_NBYTES = (ADD_WIDTH + 7) / 8;
    localparam int CNT_W      = 4;

    typedef enum logic {
        LOAD    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

endpackage

// File: rtl/add_operand_loader.sv
// Loads two operands from an LSB-first byte stream (A first, then B), presents
// them to an external single-cycle combinational adder and registers the
// result behind a valid/ready handshake.
//
// State table:
//   state   | meaning
//   LOAD    | accepting operand bytes, byte_cnt = index of next byte
//   COMPUTE | operands stable on add_a/add_b, waiting for a free output slot
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   clr                  synchronous abort of a partially loaded pair (LOAD only)
//   s_byte/s_valid/s_ready  operand byte stream
//   add_a, add_b         registered operands to the external adder
//   add_sum, add_cout    external adder result
//   m_sum, m_cout        registered result
//   m_pad_err            a pad bit above WIDTH-1 was nonzero in that pair
//   m_valid, m_ready     result handshake
//   busy                 not idle at the start of a pair
module add_operand_loader #(
    parameter int WIDTH  = add_pkg::ADD_WIDTH,
    parameter int NBYTES = add_pkg::ADD_NBYTES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [7:0]       s_byte,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic [WIDTH-1:0] m_sum,
    output logic             m_cout,
    output logic             m_pad_err,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy
);

    import add_pkg::*;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * NBYTES - 1);
    localparam logic [CNT_W-1:0] NB_CNT   = CNT_W'(NBYTES);

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;
    logic             pad_flag;

    logic             is_b;
    logic [CNT_W-1:0] op_idx;
    logic [WIDTH-1:0] op_next;
    logic [7:0]       pad_mask;
    logic             pad_hit;
    logic             slot_free;

    // Merge the incoming byte into whichever operand it belongs to; bits that
    // would land at or above WIDTH are dropped and reported through pad_hit.
    always_comb begin
        is_b    = (byte_cnt >= NB_CNT);
        op_idx  = is_b ? (byte_cnt - NB_CNT) : byte_cnt;
        op_next = is_b ? add_b : add_a;
        for (int j = 0; j < WIDTH; j++) begin
            if (op_idx == CNT_W'(j / 8)) begin
                op_next[j] = s_byte[j % 8];
            end
        end
        pad_mask = '0;
        for (int k = 0; k < NBYTES; k++) begin
            for (int i = 0; i < 8; i++) begin
                if (op_idx == CNT_W'(k) && (8 * k + i) >= WIDTH) begin
                    pad_mask[i] = 1'b1;
                end
            end
        end
        pad_hit = |(s_byte & pad_mask);
    end

    assign slot_free = !m_valid || m_ready;
    assign busy      = (state != LOAD) || (byte_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            byte_cnt  <= '0;
            pad_flag  <= 1'b0;
            s_ready   <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            m_sum     <= '0;
            m_cout    <= 1'b0;
            m_pad_err <= 1'b0;
            m_valid   <= 1'b0;
        end else begin
            // A consumed result drops valid unless a capture below refills it.
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            case (state)
                LOAD: begin
                    s_ready <= 1'b1;
                    if (clr) begin
                        byte_cnt <= '0;
                        pad_flag <= 1'b0;
                    end else if (s_valid && s_ready) begin
                        if (is_b) begin
                            add_b <= op_next;
                        end else begin
                            add_a <= op_next;
                        end
                        if (pad_hit) begin
                            pad_flag <= 1'b1;
                        end
                        if (byte_cnt == LAST_CNT) begin
                            byte_cnt <= '0;
                            state    <= COMPUTE;
                            s_ready  <= 1'b0;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (slot_free) begin
                        m_sum     <= add_sum;
                        m_cout    <= add_cout;
                        m_pad_err <= pad_flag;
                        m_valid   <= 1'b1;
                        pad_flag  <= 1'b0;
                        state     <= LOAD;
                        s_ready   <= 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_add_operand_loader.sv
// Bench for add_operand_loader. The external adder is stood in for by a
// behavioural add; expected results come from a plain arithmetic model of the
// raw 40-bit byte images.
module tb_add_operand_loader;

    localparam int W = 35;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic [7:0]   s_byte = 8'h00;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cout;
    logic [W-1:0] m_sum;
    logic         m_cout, m_pad_err, m_valid;
    logic         m_ready = 1'b0;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    add_operand_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .s_byte    (s_byte),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .m_sum     (m_sum),
        .m_cout    (m_cout),
        .m_pad_err (m_pad_err),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // {pad, cout, sum} for two raw 40-bit operand images
    function automatic logic [W+1:0] ref_result(input logic [39:0] a_raw, input logic [39:0] b_raw);
        logic [63:0] a, b, s;
        logic        pad;
        a   = {24'd0, a_raw} % (64'd1 << W);
        b   = {24'd0, b_raw} % (64'd1 << W);
        pad = (({24'd0, a_raw} >> W) != 0) || (({24'd0, b_raw} >> W) != 0);
        s   = a + b;
        return {pad, s[W], s[W-1:0]};
    endfunction

    function automatic logic [39:0] rand_raw(input bit allow_pad);
        logic [39:0] r;
        r = {8'($urandom), 32'($urandom)};
        if (!allow_pad || $urandom_range(0, 3) != 0) r[39:35] = 5'd0;
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_byte  = b;
        s_valid = 1'b1;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            errors++;
            checks++;
            $display("FAIL send_byte_timeout: s_ready=%0b required 1", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [39:0] a_raw, input logic [39:0] b_raw);
        for (int k = 0; k < 10; k++) begin
            if (k < 5) send_byte(a_raw[8*k +: 8]);
            else       send_byte(b_raw[8*(k-5) +: 8]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %0b expected 0", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %0b expected 0", m_valid); end
        checks++; if ({m_sum, m_cout, m_pad_err} !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", {m_sum, m_cout, m_pad_err}); end
        checks++; if ({add_a, add_b} !== '0) begin errors++; $display("FAIL reset_operands: got %h expected 0", {add_a, add_b}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_s_ready: got %0b expected 1", s_ready); end
    endtask

    // Sends one pair with a free slot and checks latency plus result.
    task automatic run_pair(input string name, input logic [39:0] a_raw, input logic [39:0] b_raw);
        logic [W+1:0] exp;
        exp = ref_result(a_raw, b_raw);
        send_pair(a_raw, b_raw);
        checks++; if (m_valid !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL %s_compute_cycle: valid/ready/busy got %0b%0b%0b expected 001", name, m_valid, s_ready, busy);
        end
        @(posedge clk);
        #1;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL %s_latency: m_valid got %0b expected 1", name, m_valid); end
        checks++; if ({m_pad_err, m_cout, m_sum} !== exp) begin
            errors++; $display("FAIL %s_result: got pad=%0b cout=%0b sum=%h expected pad=%0b cout=%0b sum=%h",
                               name, m_pad_err, m_cout, m_sum, exp[W+1], exp[W], exp[W-1:0]);
        end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL %s_back_to_load: s_ready got %0b expected 1", name, s_ready); end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL %s_consume: m_valid got %0b expected 0", name, m_valid); end
    endtask

    task automatic test_carry();
        run_pair("carry", 40'h07_FFFF_FFFF, 40'h00_0000_0001);
        checks++; if (m_sum !== '0 || m_cout !== 1'b1) begin errors++; $display("FAIL carry_wrap: got cout=%0b sum=%h expected cout=1 sum=0", m_cout, m_sum); end
    endtask

    task automatic test_known();
        run_pair("known", 40'h01_2345_6789, 40'h00_FEDC_BA98);
        checks++; if (m_sum !== 35'h2_2222_2221) begin errors++; $display("FAIL known_sum: got %h expected 222222221", m_sum); end
    endtask

    task automatic test_pad();
        run_pair("pad_set", 40'h0F_0000_0001, 40'h00_1234_5678);
        checks++; if (add_a !== 35'h7_0000_0001) begin errors++; $display("FAIL pad_truncate: add_a got %h expected 700000001", add_a); end
        run_pair("pad_clean", 40'h03_0000_0010, 40'h00_0000_0020);
    endtask

    task automatic test_stall();
        logic [39:0]  a1, b1, a2, b2;
        logic [W+1:0] e1, e2;
        a1 = rand_raw(1'b1); b1 = rand_raw(1'b1);
        a2 = rand_raw(1'b1); b2 = rand_raw(1'b1);
        e1 = ref_result(a1, b1);
        e2 = ref_result(a2, b2);
        m_ready = 1'b0;
        send_pair(a1, b1);
        @(posedge clk);
        #1;
        send_pair(a2, b2);
        for (int i = 0; i < 4; i++) begin
            clr = (i == 1);
            @(posedge clk);
            #1;
            clr = 1'b0;
            checks++; if (m_valid !== 1'b1 || {m_pad_err, m_cout, m_sum} !== e1) begin
                errors++; $display("FAIL stall_hold: valid=%0b result=%h expected valid=1 result=%h", m_valid, {m_pad_err, m_cout, m_sum}, e1);
            end
            checks++; if (s_ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL stall_compute: s_ready/busy got %0b%0b expected 01", s_ready, busy);
            end
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (m_valid !== 1'b1 || {m_pad_err, m_cout, m_sum} !== e2) begin
            errors++; $display("FAIL stall_release: valid=%0b result=%h expected valid=1 result=%h", m_valid, {m_pad_err, m_cout, m_sum}, e2);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: m_valid got %0b expected 0", m_valid); end
    endtask

    task automatic test_clr();
        logic [39:0]  pa, pb, fa, fb, junk;
        logic [W+1:0] ep, ef;
        int           npre;
        for (int t = 0; t < 2; t++) begin
            npre = (t == 0) ? 3 : 5;
            pa = rand_raw(1'b0); pb = rand_raw(1'b0);
            fa = rand_raw(1'b0); fb = rand_raw(1'b0);
            junk = {8'hF8, 32'($urandom)};
            ep = ref_result(pa, pb);
            ef = ref_result(fa, fb);
            m_ready = 1'b0;
            send_pair(pa, pb);
            @(posedge clk);
            #1;
            for (int k = 0; k < npre; k++) send_byte(junk[8*k +: 8]);
            s_byte  = 8'($urandom);
            s_valid = 1'b1;
            clr     = 1'b1;
            @(posedge clk);
            #1;
            clr     = 1'b0;
            s_valid = 1'b0;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_count: busy got %0b expected 0 (after %0d bytes)", busy, npre); end
            checks++; if (m_valid !== 1'b1 || {m_pad_err, m_cout, m_sum} !== ep) begin
                errors++; $display("FAIL clr_output_kept: valid=%0b result=%h expected valid=1 result=%h", m_valid, {m_pad_err, m_cout, m_sum}, ep);
            end
            send_pair(fa, fb);
            m_ready = 1'b1;
            @(posedge clk);
            #1;
            checks++; if (m_valid !== 1'b1 || {m_pad_err, m_cout, m_sum} !== ef) begin
                errors++; $display("FAIL clr_fresh_result: valid=%0b result=%h expected valid=1 result=%h", m_valid, {m_pad_err, m_cout, m_sum}, ef);
            end
            @(posedge clk);
            #1;
            m_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [39:0]  a, b;
        logic [W+1:0] e;
        int           prev;
        prev = 0;
        m_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            a = rand_raw(1'b1);
            b = rand_raw(1'b1);
            e = ref_result(a, b);
            send_pair(a, b);
            @(posedge clk);
            #1;
            checks++; if (m_valid !== 1'b1 || {m_pad_err, m_cout, m_sum} !== e) begin
                errors++; $display("FAIL b2b_result_%0d: valid=%0b result=%h expected valid=1 result=%h", n, m_valid, {m_pad_err, m_cout, m_sum}, e);
            end
            if (n > 0) begin
                checks++; if (cyc - prev !== 11) begin errors++; $display("FAIL b2b_period_%0d: got %0d cycles expected 11", n, cyc - prev); end
            end
            prev = cyc;
        end
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: m_valid got %0b expected 0", m_valid); end
    endtask

    task automatic test_reset_compute();
        int seen;
        run_pair("pre_reset", 40'h00_0000_00FF, 40'h00_0000_0101);
        send_pair(40'h05_5555_5555, 40'h02_AAAA_AAAA);
        rst_n = 1'b0;
        #1;
        checks++; if ({m_valid, m_sum, m_cout, m_pad_err} !== '0) begin
            errors++; $display("FAIL rst_compute_outputs: got %h expected 0", {m_valid, m_sum, m_cout, m_pad_err});
        end
        checks++; if ({add_a, add_b, s_ready, busy} !== '0) begin
            errors++; $display("FAIL rst_compute_state: got %h expected 0", {add_a, add_b, s_ready, busy});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (m_valid === 1'b1) seen++;
        end
        m_ready = 1'b0;
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_compute_no_result: m_valid seen %0d cycles expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_known();
        test_pad();
        test_stall();
        test_clr();
        test_back_to_back();
        test_reset_compute();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
